mem_access_unit: RTL and testbench

- MEM-stage data-memory access unit. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- It turns load/store control plus address/store data into a handshaked word-bus transaction.
- It aligns and extends sub-word load data to produce the 32-bit Data_out latched by MEM/WB.
- It stalls the pipeline while a transaction is outstanding and flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Handshaked word bus between the MEM-stage access unit (master) and data memory (slave).
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_be,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_be,
      input  mem_wdata,
      output mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns load/store control into one word-bus
// transaction, stalls the pipeline while it is outstanding and formats load data.
module mem_access_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      MemRead,
   input  logic                      MemWrite,
   input  logic [1:0]                size,
   input  logic                      sign_ext,
   input  logic [31:0]               addr,
   input  logic [31:0]               wdata,
   output logic [31:0]               Data_out,
   output logic                      stall,
   output logic                      misalign,
   output logic                      bus_err,
   mem_access_unit_if.master         bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] lo);
      logic ok;
      case (sz)
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~lo[0];
         default: ok = (lo == 2'b00);
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] lo);
      logic [3:0] be;
      case (sz)
         2'b00:   be = 4'b0001 << lo;
         2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicating the store data across every lane lets memory pick it up from any enabled byte.
   function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] res;
      case (sz)
         2'b00:   res = {4{wd[7:0]}};
         2'b01:   res = {2{wd[15:0]}};
         default: res = wd;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] format_load(input logic [1:0]  sz,
                                               input logic [1:0]  lo,
                                               input logic        sx,
                                               input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lo)
         2'b00:   b = rd[7:0];
         2'b01:   b = rd[15:8];
         2'b10:   b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = lo[1] ? rd[31:16] : rd[15:0];
      case (sz)
         2'b00:   res = {{24{sx & b[7]}}, b};
         2'b01:   res = {{16{sx & h[15]}}, h};
         default: res = rd;
      endcase
      return res;
   endfunction

   logic             access_s;
   logic             aligned_s;
   logic             start_s;
   logic             stall_s;

   logic [1:0]       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      data_out_r;
   logic             req_r;
   logic             we_r;
   logic [31:0]      addr_r;
   logic [3:0]       be_r;
   logic [31:0]      wdata_r;
   logic [1:0]       size_r;
   logic [1:0]       lo_r;
   logic             sext_r;
   logic             misalign_r;
   logic             bus_err_r;

   assign access_s  = MemRead | MemWrite;
   assign aligned_s = is_aligned(size, addr[1:0]);
   assign start_s   = (state_r == ST_IDLE) & access_s & aligned_s;

   // Pipeline freeze: asserted from the issuing cycle through the last BUSY cycle.
   always_comb begin
      stall_s = 1'b0;
      case (state_r)
         ST_IDLE: stall_s = access_s & aligned_s;
         ST_BUSY: stall_s = 1'b1;
         default: stall_s = 1'b0;
      endcase
   end

   // Transaction FSM and wait-cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r <= ST_BUSY;
                  cnt_r   <= '0;
               end
            end
            ST_BUSY: begin
               if (bus.mem_ready || (cnt_r == CNT_LAST)) begin
                  state_r <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_DONE: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Bus request and the attributes latched at issue, held until the transaction ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= 32'h0000_0000;
         be_r    <= 4'b0000;
         wdata_r <= 32'h0000_0000;
         size_r  <= 2'b00;
         lo_r    <= 2'b00;
         sext_r  <= 1'b0;
      end else if (start_s) begin
         req_r   <= 1'b1;
         we_r    <= MemWrite;
         addr_r  <= {addr[31:2], 2'b00};
         be_r    <= byte_enables(size, addr[1:0]);
         wdata_r <= store_data(size, wdata);
         size_r  <= size;
         lo_r    <= addr[1:0];
         sext_r  <= sign_ext;
      end else if ((state_r == ST_BUSY) && (bus.mem_ready || (cnt_r == CNT_LAST))) begin
         req_r <= 1'b0;
      end
   end

   // Load result: formatted with the attributes captured at issue, not the live inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_r <= 32'h0000_0000;
      end else if ((state_r == ST_BUSY) && bus.mem_ready && !we_r) begin
         data_out_r <= format_load(size_r, lo_r, sext_r, bus.mem_rdata);
      end
   end

   // Single-cycle status pulses; they come from different states so never overlap.
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_r <= 1'b0;
         bus_err_r  <= 1'b0;
      end else begin
         misalign_r <= (state_r == ST_IDLE) & access_s & ~aligned_s;
         bus_err_r  <= (state_r == ST_BUSY) & ~bus.mem_ready & (cnt_r == CNT_LAST);
      end
   end

   assign Data_out      = data_out_r;
   assign stall         = stall_s;
   assign misalign      = misalign_r;
   assign bus_err       = bus_err_r;
   assign bus.mem_req   = req_r;
   assign bus.mem_we    = we_r;
   assign bus.mem_addr  = addr_r;
   assign bus.mem_be    = be_r;
   assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit against a byte-arithmetic reference model.
module tb_mem_access_unit;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] Data_out;
   logic        stall;
   logic        misalign;
   logic        bus_err;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_dout;

   mem_access_unit_if bus_if ();

   mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .size     (size),
      .sign_ext (sign_ext),
      .addr     (addr),
      .wdata    (wdata),
      .Data_out (Data_out),
      .stall    (stall),
      .misalign (misalign),
      .bus_err  (bus_err),
      .bus      (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                              input logic sx, input logic [31:0] rd);
      int          n    = nbytes(sz);
      logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
      logic [31:0] v    = (rd >> (8 * int'(a[1:0]))) & mask;
      if (n < 4 && sx && v[8 * n - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
      int t = ((1 << nbytes(sz)) - 1) << int'(a[1:0]);
      return t[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      int          n = nbytes(sz);
      for (int k = 0; k < 4; k++) r[8 * k +: 8] = wd[8 * (k % n) +: 8];
      return r;
   endfunction

   task automatic clear_inputs();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
   endtask

   // One access from IDLE back to IDLE; waits >= TIMEOUT means memory never answers.
   task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int waits, input bit drop);
      int n         = nbytes(sz);
      bit ok        = (int'(a[1:0]) % n) == 0;
      bit tout      = (waits >= TIMEOUT);
      int n_busy    = tout ? TIMEOUT : waits + 1;
      int stall_cnt = 0;
      MemRead  = rd;
      MemWrite = wr;
      size     = sz;
      sign_ext = sx;
      addr     = a;
      wdata    = wd;
      #1;
      if (!ok) begin
         check({tag, "_mis_stall0"}, 32'(stall), 32'd0);
         step();
         check({tag, "_mis_pulse"}, 32'(misalign), 32'd1);
         check({tag, "_mis_noreq"}, 32'(bus_if.mem_req), 32'd0);
         check({tag, "_mis_stall1"}, 32'(stall), 32'd0);
         clear_inputs();
         step();
         check({tag, "_mis_clear"}, 32'(misalign), 32'd0);
         return;
      end
      if (stall === 1'b1) stall_cnt++;
      step();
      check({tag, "_addr"}, bus_if.mem_addr, {a[31:2], 2'b00});
      check({tag, "_be"}, 32'(bus_if.mem_be), 32'(model_be(sz, a)));
      check({tag, "_we"}, 32'(bus_if.mem_we), 32'(wr));
      check({tag, "_wdata"}, bus_if.mem_wdata, model_wdata(sz, wd));
      for (int i = 0; i < n_busy; i++) begin
         bus_if.mem_ready = (i == waits) ? 1'b1 : 1'b0;
         bus_if.mem_rdata = (i == waits) ? rdat : $urandom;
         #1;
         if (stall === 1'b1) stall_cnt++;
         check({tag, "_busy_req"}, 32'(bus_if.mem_req), 32'd1);
         step();
         if (i == 0 && drop) begin
            clear_inputs();
            addr  = $urandom;
            wdata = $urandom;
         end
      end
      bus_if.mem_ready = 1'b0;
      bus_if.mem_rdata = $urandom;
      #1;
      if (rd && !wr && !tout) exp_dout = model_load(sz, a, sx, rdat);
      if (stall === 1'b1) stall_cnt++;
      check({tag, "_done_req"}, 32'(bus_if.mem_req), 32'd0);
      check({tag, "_done_buserr"}, 32'(bus_err), 32'(tout));
      check({tag, "_done_misalign"}, 32'(misalign), 32'd0);
      check({tag, "_dout"}, Data_out, exp_dout);
      check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(tout ? TIMEOUT + 1 : waits + 2));
      step();
      check({tag, "_idle_noreissue"}, 32'(bus_if.mem_req), 32'd0);
      check({tag, "_idle_buserr"}, 32'(bus_err), 32'd0);
      clear_inputs();
   endtask

   initial begin
      int          kind;
      logic [31:0] ra;
      reset            = 1'b1;
      MemRead          = 1'b0;
      MemWrite         = 1'b0;
      size             = 2'b00;
      sign_ext         = 1'b0;
      addr             = 32'h0;
      wdata            = 32'h0;
      bus_if.mem_rdata = 32'h0;
      bus_if.mem_ready = 1'b0;
      exp_dout         = 32'h0;
      step();
      step();
      check("rst_dout", Data_out, 32'h0);
      check("rst_req", 32'(bus_if.mem_req), 32'd0);
      check("rst_we", 32'(bus_if.mem_we), 32'd0);
      check("rst_addr", bus_if.mem_addr, 32'h0);
      check("rst_be", 32'(bus_if.mem_be), 32'd0);
      check("rst_wdata", bus_if.mem_wdata, 32'h0);
      check("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      reset = 1'b0;
      step();

      run_op("sw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      run_op("lb_s", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0, 1'b0);
      check("lb_s_const", Data_out, 32'hFFFF_FF80);
      run_op("lb_u", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0, 1'b0);
      check("lb_u_const", Data_out, 32'h0000_0080);
      run_op("lh_hi", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0, 1'b0);
      check("lh_hi_const", Data_out, 32'hFFFF_8001);
      run_op("lh_lo", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0, 32'h8001_7FFF, 0, 1'b0);
      check("lh_lo_const", Data_out, 32'h0000_7FFF);
      run_op("lw_mis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 0, 1'b0);
      run_op("sh_mis", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h1234_5678, 32'h0, 0, 1'b0);
      run_op("tmo", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678, TIMEOUT, 1'b0);
      check("tmo_const", Data_out, 32'h0000_7FFF);
      run_op("wait3", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0408, 32'h0, 32'hCAFE_F00D, 3, 1'b1);
      run_op("both", 1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_0506, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 1, 1'b0);

      // Reset while a read is outstanding.
      MemRead  = 1'b1;
      MemWrite = 1'b0;
      size     = 2'b10;
      addr     = 32'h0000_0300;
      #1;
      step();
      check("mid_busy_req", 32'(bus_if.mem_req), 32'd1);
      reset = 1'b1;
      clear_inputs();
      step();
      exp_dout = 32'h0;
      check("mid_rst_req", 32'(bus_if.mem_req), 32'd0);
      check("mid_rst_stall", 32'(stall), 32'd0);
      check("mid_rst_dout", Data_out, 32'h0);
      check("mid_rst_be", 32'(bus_if.mem_be), 32'd0);
      reset = 1'b0;
      step();
      run_op("post_rst", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0301, 32'h0, 32'h0000_7F00, 0, 1'b0);

      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 3);
         ra   = $urandom;
         if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
         run_op("rnd", (kind != 1), (kind == 1 || kind == 2), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ra, $urandom, $urandom,
                ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 4),
                1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
